alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 32-bit `alu` datapath between `N_REQ` requesters (e.g. the integer pipe and the address/branch helper) with a valid/ready handshake on each side. It runs round-robin arbitration, registers the operands, sequences the ALU through a three-state FSM, and returns a registered result to the granted requester. It sits between the issue logic and the ALU. It is the only block that drives the ALU's `ALU_Sel`, `tmpA` and `tmpB` inputs.

## Interface
- `N_REQ`, default 2: number of requesters (2..8).
- `IDW`, default `$clog2(N_REQ)`: width of the grant index.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, `N_REQ` bits: request pending, one bit per requester.
- `req_ready` output, `N_REQ` bits: request accepted this cycle; at most one bit is set (one-hot).
- `req_op` input, `4*N_REQ` bits: ALU select per requester; slice i is `[4i+3:4i]`.
- `req_a` input, `32*N_REQ` bits: operand A per requester.
- `req_b` input, `32*N_REQ` bits: operand B per requester.
- `rsp_valid` output, `N_REQ` bits: result valid for requester i; one-hot.
- `rsp_ready` input, `N_REQ` bits: requester i consumes the result.
- `rsp_data` output, 32 bits: registered ALU result.
- `rsp_err` output, 1 bit: the op code was undefined (see Configuration).
- `gnt_id` output, `IDW` bits: index of the requester currently owning the ALU.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` bit is set, grant the first set bit found by scanning upward from `rr_ptr`, wrapping modulo `N_REQ`.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Latch `op`, `a`, `b` and `g`, then go to EXEC.
  - `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **EXEC**
  - Drive the ALU from the latched registers only.
  - Register the ALU output into `rsp_data` and the error flag into `rsp_err`.
  - Go to RESP. `req_ready` is all zeros.
- **RESP**
  - Hold `rsp_valid[g]` = 1, with `rsp_data` and `rsp_err` stable, until `rsp_ready[g]` = 1.
  - On that handshake:
    - set `rr_ptr` = (g+1) mod `N_REQ`;
    - if any request is pending, arbitrate using the updated pointer and go straight to EXEC with the new winner (back-to-back grant);
    - otherwise go to IDLE.
- `rsp_ready` bits for requesters other than g are ignored.
- `rr_ptr` advances only on a response handshake. A requester that keeps `req_valid` high is served within `N_REQ` grants (no starvation).
- ALU function codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra.
  - 9 slt (signed compare), 10 sltu (unsigned compare).
  - Any other code produces a result of 0.
- The shift amount is the full 32-bit B value. Results are 32-bit and wrap modulo 2^32.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `gnt_id` = 0, `rr_ptr` = 0, state = IDLE.
- Latency: accept in cycle T gives `rsp_valid` in cycle T+2.
- Throughput: one operation per 2 cycles with `rsp_ready` held high, and one per 3 cycles when the FSM returns through IDLE.
- A request arriving while the FSM is in EXEC, or in RESP without a handshake, waits; `req_ready` stays 0 for it.
- Reset asserted in any state takes effect at the next edge:
  - any in-flight operation is discarded with no response;
  - the pointer returns to 0;
  - reset has priority over all handshakes in the same cycle.
- A requester with `req_valid` and a `rsp_ready` handshake in the same cycle is legal. It may be re-granted only if the rotation reaches it.

## Configuration
- Macro `ALU_ARB_ERR_EN`.
- **Defined:**
  - `rsp_err` = 1 for op codes 8 and 11 through 15; `rsp_data` is still 0.
  - A sticky internal counter `err_cnt` (16 bits, saturating) increments on each erroneous response handshake. It is reset by `rst`.
- **Undefined:** `rsp_err` is tied to 0 and no counter logic is synthesized. Port widths are unchanged.

## Structure
- Package `alu_pkg` holds:
  - the ALU op-code constants (`ALU_ADD` through `ALU_SLTU`);
  - the FSM state typedef (`ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`);
  - a function `alu_op_legal(op)`.
- Sub-module: one instance of the existing `alu`, fed only from the latched registers.
- The round-robin priority picker stays inline.

## Test plan
- **Single request.** Requester 0, op 0, A=5, B=7, accepted at T → `rsp_valid[0]` at T+2, `rsp_data`=12; handshake returns the FSM to IDLE.
- **Contention and rotation.** Both requesters hold valid, `rsp_ready` high → grants alternate 0,1,0,1; one `rsp_valid` every 2 cycles.
- **Signed versus unsigned compare.** Op 9 with A=0xFFFFFFFF, B=1 → 1; op 10 with the same operands → 0; op 7 with A=0x80000000, B=4 → 0xF8000000.
- **Response backpressure.** Hold `rsp_ready[1]`=0 for 5 cycles → `rsp_data` stable, `req_ready` all 0, requester 0 waits; release → requester 0 is granted in the same cycle.
- **Reset mid-operation.** Assert `rst` during EXEC → next cycle all outputs 0, state IDLE, no response; the first grant after reset goes to requester 0.
- **Illegal op.** Op 12 → `rsp_data`=0; `rsp_err`=1 with `ALU_ARB_ERR_EN` defined, 0 without it.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, arbiter FSM state type and op-legality helper.
package alu_pkg;

  localparam int unsigned OPW = 4;
  localparam int unsigned DW  = 32;

  localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [OPW-1:0] ALU_AND  = 4'd2;
  localparam logic [OPW-1:0] ALU_OR   = 4'd3;
  localparam logic [OPW-1:0] ALU_XOR  = 4'd4;
  localparam logic [OPW-1:0] ALU_SLL  = 4'd5;
  localparam logic [OPW-1:0] ALU_SRL  = 4'd6;
  localparam logic [OPW-1:0] ALU_SRA  = 4'd7;
  localparam logic [OPW-1:0] ALU_SLT  = 4'd9;
  localparam logic [OPW-1:0] ALU_SLTU = 4'd10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  function automatic logic alu_op_legal(input logic [OPW-1:0] op);
    return (op <= ALU_SRA) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; undefined op codes return zero.
module alu
  import alu_pkg::*;
(
  input  logic [OPW-1:0] ALU_Sel,
  input  logic [DW-1:0]  tmpA,
  input  logic [DW-1:0]  tmpB,
  output logic [DW-1:0]  ALU_Out
);

  // Shifts use the full 32-bit B, so amounts >= 32 flush the operand
  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      ALU_ADD:  ALU_Out = tmpA + tmpB;
      ALU_SUB:  ALU_Out = tmpA - tmpB;
      ALU_AND:  ALU_Out = tmpA & tmpB;
      ALU_OR:   ALU_Out = tmpA | tmpB;
      ALU_XOR:  ALU_Out = tmpA ^ tmpB;
      ALU_SLL:  ALU_Out = tmpA << tmpB;
      ALU_SRL:  ALU_Out = tmpA >> tmpB;
      ALU_SRA:  ALU_Out = DW'($signed(tmpA) >>> tmpB);
      ALU_SLT:  ALU_Out = DW'($signed(tmpA) < $signed(tmpB));
      ALU_SLTU: ALU_Out = DW'(tmpA < tmpB);
      default:  ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin valid/ready arbiter sharing one ALU between N_REQ requesters.
// Optional error reporting and error counter enabled by ALU_ARB_ERR_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [OPW*N_REQ-1:0] req_op,
  input  logic [DW*N_REQ-1:0]  req_a,
  input  logic [DW*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic [IDW-1:0]       gnt_id
);

  arb_state_e     state, state_n;
  logic [IDW-1:0] rr_ptr, ptr_next, arb_base, win;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q, b_q, alu_out;
  logic           take, rsp_hs;

  // First set bit scanning upward from base, wrapping modulo N_REQ
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                             input logic [IDW-1:0]   base);
    logic [IDW-1:0] w;
    logic [IDW-1:0] idx;
    w = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = IDW'((int'(base) + k) % int'(N_REQ));
      if (v[idx]) w = idx;
    end
    return w;
  endfunction

  assign ptr_next = IDW'((int'(gnt_id) + 1) % int'(N_REQ));

  alu u_alu (
    .ALU_Sel (op_q),
    .tmpA    (a_q),
    .tmpB    (b_q),
    .ALU_Out (alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_n;
  end

  // RESP arbitrates from the post-handshake pointer for back-to-back grants
  always_comb begin
    state_n   = state;
    req_ready = '0;
    take      = 1'b0;
    rsp_hs    = 1'b0;
    arb_base  = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (|req_valid) begin
          take    = 1'b1;
          state_n = ARB_EXEC;
        end
      end
      ARB_EXEC: state_n = ARB_RESP;
      ARB_RESP: begin
        arb_base = ptr_next;
        if (rsp_ready[gnt_id]) begin
          rsp_hs = 1'b1;
          if (|req_valid) begin
            take    = 1'b1;
            state_n = ARB_EXEC;
          end else begin
            state_n = ARB_IDLE;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
    win = rr_pick(req_valid, arb_base);
    if (take) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      gnt_id    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      if (rsp_hs) begin
        rr_ptr    <= ptr_next;
        rsp_valid <= '0;
      end
      if (take) begin
        gnt_id <= win;
        op_q   <= req_op[int'(win)*OPW +: OPW];
        a_q    <= req_a[int'(win)*DW +: DW];
        b_q    <= req_b[int'(win)*DW +: DW];
      end
      if (state == ARB_EXEC) begin
        rsp_data  <= alu_out;
        rsp_valid <= N_REQ'(1) << gnt_id;
      end
    end
  end

`ifdef ALU_ARB_ERR_EN
  logic [15:0] err_cnt;

  // Sticky saturating count of erroneous responses actually consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (state == ARB_EXEC) rsp_err <= !alu_op_legal(op_q);
      if (rsp_hs && rsp_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: op table plus contention, backpressure
// and reset-in-flight sequences. Honours ALU_ARB_ERR_EN for error checks.
module tb_alu_arbiter;

`ifdef ALU_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int NV = 14;

  typedef struct {
    int          rq;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [0:0]  gnt_id;

  int n_chk;
  int n_fail;
  vec_t vecs[NV];

  alu_arbiter #(.N_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .gnt_id    (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input int rq, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*rq +: 4]  = op;
    req_a[32*rq +: 32] = a;
    req_b[32*rq +: 32] = b;
  endtask

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0]  = '{0, 4'd0,  32'd5,        32'd7,        32'd12,        1'b0};
    vecs[1]  = '{1, 4'd1,  32'd3,        32'd5,        32'hFFFFFFFE,  1'b0};
    vecs[2]  = '{0, 4'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000,  1'b0};
    vecs[3]  = '{1, 4'd3,  32'h0000F0F0, 32'h00000F00, 32'h0000FFF0,  1'b0};
    vecs[4]  = '{0, 4'd4,  32'h000000FF, 32'h0000000F, 32'h000000F0,  1'b0};
    vecs[5]  = '{1, 4'd5,  32'd1,        32'd31,       32'h80000000,  1'b0};
    vecs[6]  = '{0, 4'd5,  32'd1,        32'd32,       32'h00000000,  1'b0};
    vecs[7]  = '{1, 4'd6,  32'h80000000, 32'd4,        32'h08000000,  1'b0};
    vecs[8]  = '{0, 4'd7,  32'h80000000, 32'd4,        32'hF8000000,  1'b0};
    vecs[9]  = '{1, 4'd9,  32'hFFFFFFFF, 32'd1,        32'd1,         1'b0};
    vecs[10] = '{0, 4'd10, 32'hFFFFFFFF, 32'd1,        32'd0,         1'b0};
    vecs[11] = '{1, 4'd12, 32'd9,        32'd9,        32'd0,         ERR_EN};
    vecs[12] = '{0, 4'd8,  32'd9,        32'd9,        32'd0,         ERR_EN};
    vecs[13] = '{1, 4'd0,  32'hFFFFFFFF, 32'd1,        32'd0,         1'b0};

    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    cyc();
    cyc();
    smp();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    cyc();
    rst = 1'b0;

    // Single-requester operation table: accept T, EXEC T+1, response T+2
    for (int i = 0; i < NV; i++) begin
      req_op = '0;
      req_a = '0;
      req_b = '0;
      drive(vecs[i].rq, vecs[i].op, vecs[i].a, vecs[i].b);
      req_valid = '0;
      req_valid[vecs[i].rq] = 1'b1;
      smp();
      chk($sformatf("v%0d_accept", i), 32'(req_ready), oh(vecs[i].rq));
      cyc();
      req_valid = '0;
      smp();
      chk($sformatf("v%0d_exec_valid", i), 32'(rsp_valid), 32'd0);
      cyc();
      rsp_ready[vecs[i].rq] = 1'b1;
      smp();
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), oh(vecs[i].rq));
      chk($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp);
      chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_gnt_id", i), 32'(gnt_id), 32'(vecs[i].rq));
      cyc();
      rsp_ready = '0;
      smp();
      chk($sformatf("v%0d_idle_valid", i), 32'(rsp_valid), 32'd0);
      cyc();
    end

    // Contention: pointer at 0 after reset, grants alternate 0,1,0,1
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(0, 4'd0, 32'd1, 32'd1);
    drive(1, 4'd0, 32'd10, 32'd10);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      smp();
      if (k % 2 == 0) begin
        chk($sformatf("cont_rdy_k%0d", k), 32'(req_ready), oh((k / 2) % 2));
        if (k >= 2) begin
          chk($sformatf("cont_rsp_k%0d", k), 32'(rsp_valid), oh((k / 2 - 1) % 2));
          chk($sformatf("cont_data_k%0d", k), rsp_data, ((k / 2 - 1) % 2 == 1) ? 32'd20 : 32'd2);
        end else begin
          chk($sformatf("cont_rsp_k%0d", k), 32'(rsp_valid), 32'd0);
        end
      end else begin
        chk($sformatf("cont_rdy_k%0d", k), 32'(req_ready), 32'd0);
        chk($sformatf("cont_rsp_k%0d", k), 32'(rsp_valid), 32'd0);
        chk($sformatf("cont_gnt_k%0d", k), 32'(gnt_id), 32'(((k - 1) / 2) % 2));
      end
      cyc();
    end
    req_valid = '0;
    smp();
    chk("cont_last_rsp", 32'(rsp_valid), 32'd2);
    chk("cont_last_data", rsp_data, 32'd20);
    chk("cont_last_rdy", 32'(req_ready), 32'd0);
    cyc();
    rsp_ready = '0;
    smp();
    chk("cont_idle_rsp", 32'(rsp_valid), 32'd0);
    cyc();

    // Backpressure: requester 1 holds its response, requester 0 waits
    drive(1, 4'd1, 32'd10, 32'd3);
    drive(0, 4'd0, 32'd100, 32'd1);
    req_valid = 2'b10;
    smp();
    chk("bp_accept1", 32'(req_ready), 32'd2);
    cyc();
    req_valid = 2'b11;
    smp();
    chk("bp_exec_rdy", 32'(req_ready), 32'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      smp();
      chk($sformatf("bp_hold_valid%0d", i), 32'(rsp_valid), 32'd2);
      chk($sformatf("bp_hold_data%0d", i), rsp_data, 32'd7);
      chk($sformatf("bp_hold_rdy%0d", i), 32'(req_ready), 32'd0);
      cyc();
    end
    rsp_ready = 2'b10;
    smp();
    chk("bp_release_rdy", 32'(req_ready), 32'd1);
    chk("bp_release_valid", 32'(rsp_valid), 32'd2);
    cyc();
    req_valid = '0;
    rsp_ready = '0;
    smp();
    chk("bp_exec0_valid", 32'(rsp_valid), 32'd0);
    cyc();
    smp();
    chk("bp_rsp0_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp0_data", rsp_data, 32'd101);
    chk("bp_rsp0_gnt", 32'(gnt_id), 32'd0);
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = '0;
    smp();
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    cyc();

    // Reset during EXEC: pointer now 1, so requester 1 wins first
    drive(0, 4'd0, 32'd40, 32'd2);
    drive(1, 4'd0, 32'd7, 32'd7);
    req_valid = 2'b11;
    smp();
    chk("rst_pre_grant", 32'(req_ready), 32'd2);
    cyc();
    rst = 1'b1;
    req_valid = '0;
    smp();
    cyc();
    smp();
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_data", rsp_data, 32'd0);
    chk("rst_mid_err", 32'(rsp_err), 32'd0);
    chk("rst_mid_gnt", 32'(gnt_id), 32'd0);
    chk("rst_mid_rdy", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0;
    req_valid = 2'b11;
    smp();
    chk("rst_first_grant", 32'(req_ready), 32'd1);
    cyc();
    req_valid = '0;
    smp();
    chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
    cyc();
    smp();
    chk("rst_rsp_valid0", 32'(rsp_valid), 32'd1);
    chk("rst_rsp_data0", rsp_data, 32'd42);
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = '0;
    smp();
    chk("rst_end_valid", 32'(rsp_valid), 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
